// File: rtl/aha_par_pkg.sv
// Shared types and constants for the parallel-interface target fabric.
// Pure declarations: no latency, no flow control.
package aha_par_pkg;

    localparam int PAR_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } par_state_e;

    // Ceiling log2, never less than 1 so a counter always has at least one bit.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/aha_par_addr_decode.sv
// Address-to-target decoder: combinational, zero latency, no flow control.
// valid_o is low for indices beyond NUM_TARGETS or for unpopulated targets.
module aha_par_addr_decode #(
    parameter int                     ADDR_WIDTH     = 12,
    parameter int                     TGT_ADDR_WIDTH = 10,
    parameter int                     NUM_TARGETS    = 4,
    parameter logic [NUM_TARGETS-1:0] TGT_MASK       = {NUM_TARGETS{1'b1}}
) (
    input  logic [ADDR_WIDTH-1:0]                addr_i,
    output logic [ADDR_WIDTH-TGT_ADDR_WIDTH-1:0] sel_o,
    output logic                                 valid_o
);

    localparam int SEL_W = ADDR_WIDTH - TGT_ADDR_WIDTH;

    logic [SEL_W-1:0] sel;

    assign sel   = addr_i[ADDR_WIDTH-1:TGT_ADDR_WIDTH];
    assign sel_o = sel;

    always_comb begin
        valid_o = 1'b0;
        for (int i = 0; i < NUM_TARGETS; i++) begin
            if (sel == SEL_W'(i)) begin
                valid_o = TGT_MASK[i];
            end
        end
    end

endmodule

// File: rtl/aha_par_target_mux.sv
// Routes single-cycle parallel requests to one of NUM_TARGETS register blocks.
// Request->target 1 cycle, target response->upstream 1 cycle; requests outside IDLE are ignored.
module aha_par_target_mux
    import aha_par_pkg::*;
#(
    parameter int                     ADDR_WIDTH     = 12,
    parameter int                     TGT_ADDR_WIDTH = 10,
    parameter int                     NUM_TARGETS    = 4,
    parameter logic [NUM_TARGETS-1:0] TGT_MASK       = {NUM_TARGETS{1'b1}},
    parameter int                     TIMEOUT        = 64
) (
    input  logic                                  HCLK,
    input  logic                                  HRESETn,
    input  logic [ADDR_WIDTH-1:0]                 S_ADDR,
    input  logic                                  S_RD_EN,
    input  logic                                  S_WR_EN,
    input  logic [3:0]                            S_WR_STRB,
    input  logic [PAR_DATA_WIDTH-1:0]             S_WR_DATA,
    output logic [PAR_DATA_WIDTH-1:0]             S_RD_DATA,
    output logic                                  S_ACK,
    output logic                                  S_NACK,
    output logic [TGT_ADDR_WIDTH-1:0]             T_ADDR,
    output logic [NUM_TARGETS-1:0]                T_RD_EN,
    output logic [NUM_TARGETS-1:0]                T_WR_EN,
    output logic [3:0]                            T_WR_STRB,
    output logic [PAR_DATA_WIDTH-1:0]             T_WR_DATA,
    input  logic [PAR_DATA_WIDTH*NUM_TARGETS-1:0] T_RD_DATA,
    input  logic [NUM_TARGETS-1:0]                T_ACK,
    input  logic [NUM_TARGETS-1:0]                T_NACK,
    output logic                                  TIMEOUT_EVT
);

    localparam int SEL_W = ADDR_WIDTH - TGT_ADDR_WIDTH;
    localparam int CNT_W = clog2(TIMEOUT);
    localparam int DW    = PAR_DATA_WIDTH;

    par_state_e            state_q,     state_d;
    logic [SEL_W-1:0]      sel_q,       sel_d;
    logic                  wr_q,        wr_d;
    logic [CNT_W-1:0]      cnt_q,       cnt_d;
    logic [TGT_ADDR_WIDTH-1:0] t_addr_q, t_addr_d;
    logic [3:0]            t_strb_q,    t_strb_d;
    logic [DW-1:0]         t_wdata_q,   t_wdata_d;
    logic [NUM_TARGETS-1:0] t_rd_en_q,  t_rd_en_d;
    logic [NUM_TARGETS-1:0] t_wr_en_q,  t_wr_en_d;
    logic                  s_ack_q,     s_ack_d;
    logic                  s_nack_q,    s_nack_d;
    logic [DW-1:0]         s_rd_data_q, s_rd_data_d;
    logic                  tevt_q,      tevt_d;

    logic [SEL_W-1:0]       dec_sel;
    logic                   dec_vld;
    logic [NUM_TARGETS-1:0] dec_onehot;
    logic                   sel_ack;
    logic                   sel_nack;
    logic [DW-1:0]          sel_rdata;

    aha_par_addr_decode #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .TGT_ADDR_WIDTH (TGT_ADDR_WIDTH),
        .NUM_TARGETS    (NUM_TARGETS),
        .TGT_MASK       (TGT_MASK)
    ) u_decode (
        .addr_i  (S_ADDR),
        .sel_o   (dec_sel),
        .valid_o (dec_vld)
    );

    // Only the latched target's response lines matter; all others are masked off.
    always_comb begin
        dec_onehot = '0;
        sel_ack    = 1'b0;
        sel_nack   = 1'b0;
        sel_rdata  = '0;
        for (int i = 0; i < NUM_TARGETS; i++) begin
            if (dec_sel == SEL_W'(i)) begin
                dec_onehot[i] = 1'b1;
            end
            if (sel_q == SEL_W'(i)) begin
                sel_ack   = T_ACK[i];
                sel_nack  = T_NACK[i];
                sel_rdata = T_RD_DATA[i*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        wr_d        = wr_q;
        cnt_d       = cnt_q;
        t_addr_d    = t_addr_q;
        t_strb_d    = t_strb_q;
        t_wdata_d   = t_wdata_q;
        t_rd_en_d   = '0;
        t_wr_en_d   = '0;
        s_ack_d     = 1'b0;
        s_nack_d    = 1'b0;
        s_rd_data_d = '0;
        tevt_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (S_RD_EN || S_WR_EN) begin
                    sel_d = dec_sel;
                    wr_d  = S_WR_EN;
                    if (!dec_vld) begin
                        state_d  = ST_RESP;
                        s_nack_d = 1'b1;
                    end else begin
                        state_d   = ST_ISSUE;
                        cnt_d     = '0;
                        t_addr_d  = S_ADDR[TGT_ADDR_WIDTH-1:0];
                        t_strb_d  = S_WR_STRB;
                        t_wdata_d = S_WR_DATA;
                        if (S_WR_EN) begin
                            t_wr_en_d = dec_onehot;
                        end else begin
                            t_rd_en_d = dec_onehot;
                        end
                    end
                end
            end
            ST_ISSUE, ST_WAIT: begin
                // A response in the final counted cycle still beats the timeout.
                if (sel_nack) begin
                    state_d  = ST_RESP;
                    s_nack_d = 1'b1;
                end else if (sel_ack) begin
                    state_d     = ST_RESP;
                    s_ack_d     = 1'b1;
                    s_rd_data_d = wr_q ? '0 : sel_rdata;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d  = ST_RESP;
                    s_nack_d = 1'b1;
                    tevt_d   = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            wr_q        <= 1'b0;
            cnt_q       <= '0;
            t_addr_q    <= '0;
            t_strb_q    <= '0;
            t_wdata_q   <= '0;
            t_rd_en_q   <= '0;
            t_wr_en_q   <= '0;
            s_ack_q     <= 1'b0;
            s_nack_q    <= 1'b0;
            s_rd_data_q <= '0;
            tevt_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            wr_q        <= wr_d;
            cnt_q       <= cnt_d;
            t_addr_q    <= t_addr_d;
            t_strb_q    <= t_strb_d;
            t_wdata_q   <= t_wdata_d;
            t_rd_en_q   <= t_rd_en_d;
            t_wr_en_q   <= t_wr_en_d;
            s_ack_q     <= s_ack_d;
            s_nack_q    <= s_nack_d;
            s_rd_data_q <= s_rd_data_d;
            tevt_q      <= tevt_d;
        end
    end

    assign S_RD_DATA   = s_rd_data_q;
    assign S_ACK       = s_ack_q;
    assign S_NACK      = s_nack_q;
    assign T_ADDR      = t_addr_q;
    assign T_RD_EN     = t_rd_en_q;
    assign T_WR_EN     = t_wr_en_q;
    assign T_WR_STRB   = t_strb_q;
    assign T_WR_DATA   = t_wdata_q;
    assign TIMEOUT_EVT = tevt_q;

endmodule
